// File: rtl/ual_issue_if.sv
// ---------------------------------------------------------------------------
// ual_issue_if : handshake and ALU bus bundle for the ual_issue block.
//   req_*    : instruction request channel (valid/ready, opcode, operands)
//   alu_*    : operands/opcode driven to the external combinational ALU and
//              its result/flags returned
//   res_*    : registered result channel (valid/ready, result, flags, error)
//   flags_q  : sticky flags of the last completed supported operation
//   op_cnt   : number of completed operations (wraps at 16 bits)
// Modports: slave = the ual_issue block, master = requester/ALU/consumer side.
// ---------------------------------------------------------------------------
interface ual_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic [4:0]  alu_op;
  logic [15:0] alu_S;
  logic [4:0]  alu_flag;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_S;
  logic [4:0]  res_flag;
  logic        res_err;
  logic [4:0]  flags_q;
  logic [15:0] op_cnt;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_S, alu_flag, res_ready,
    output req_ready, alu_A, alu_B, alu_op, res_valid, res_S, res_flag,
           res_err, flags_q, op_cnt
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_S, alu_flag, res_ready,
    input  req_ready, alu_A, alu_B, alu_op, res_valid, res_S, res_flag,
           res_err, flags_q, op_cnt
  );
endinterface

// File: rtl/ual_issue.sv
// ---------------------------------------------------------------------------
// ual_issue : issues one instruction at a time to an external combinational
// ALU. Three-state FSM (IDLE -> EXEC -> DONE). A request accepted in IDLE is
// presented to the ALU for exactly one EXEC cycle; the ALU result is captured
// at the end of EXEC and held in DONE until the consumer takes it.
// Compares (EQU/INF/INFE/SUP/SUPE) run as a subtraction and are resolved
// from the Z, N and O flags as signed conditions.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : ual_issue_if.slave (request, ALU, result and status signals)
// ---------------------------------------------------------------------------
module ual_issue (
  input logic       CLK,
  input logic       RST,
  ual_issue_if.slave bus
);

  localparam int DATA_W = 16;

  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_DIV  = 5'h04;
  localparam logic [4:0] OP_SOU  = 5'h03;
  localparam logic [4:0] OP_EQU  = 5'h09;
  localparam logic [4:0] OP_INF  = 5'h0A;
  localparam logic [4:0] OP_INFE = 5'h0B;
  localparam logic [4:0] OP_SUP  = 5'h0C;
  localparam logic [4:0] OP_SUPE = 5'h0D;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic [4:0]          r_op;
  logic [DATA_W-1:0]   r_alu_A;
  logic [DATA_W-1:0]   r_alu_B;
  logic [4:0]          r_alu_op;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_S;
  logic [4:0]          r_res_flag;
  logic                r_res_err;
  logic [4:0]          r_flags_q;
  logic [15:0]         r_op_cnt;

  function automatic logic f_is_arith(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_DIV);
  endfunction

  function automatic logic f_is_cmp(input logic [4:0] op);
    return (op >= OP_EQU) && (op <= OP_SUPE);
  endfunction

  // Compares are executed as a subtraction; unsupported opcodes drive 0.
  function automatic logic [4:0] f_alu_op(input logic [4:0] op);
    if (f_is_arith(op))    return op;
    else if (f_is_cmp(op)) return OP_SOU;
    else                   return 5'h00;
  endfunction

  // Signed compare from subtraction flags: less-than is N xor O.
  function automatic logic [DATA_W-1:0] f_cmp(input logic [4:0] op,
                                              input logic z, input logic l);
    logic hit;
    case (op)
      OP_EQU:  hit = z;
      OP_INF:  hit = l;
      OP_INFE: hit = l | z;
      OP_SUP:  hit = ~l & ~z;
      OP_SUPE: hit = ~l;
      default: hit = 1'b0;
    endcase
    return {{(DATA_W-1){1'b0}}, hit};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_op        <= '0;
      r_alu_A     <= '0;
      r_alu_B     <= '0;
      r_alu_op    <= '0;
      r_res_valid <= 1'b0;
      r_res_S     <= '0;
      r_res_flag  <= '0;
      r_res_err   <= 1'b0;
      r_flags_q   <= '0;
      r_op_cnt    <= '0;
    end else begin
      case (r_state)
        // Accept: latch the request straight into the ALU drive registers.
        S_IDLE: begin
          if (bus.req_valid) begin
            r_state     <= S_EXEC;
            r_req_ready <= 1'b0;
            r_op        <= bus.req_op;
            r_alu_A     <= bus.req_a;
            r_alu_B     <= bus.req_b;
            r_alu_op    <= f_alu_op(bus.req_op);
          end
        end
        // Execute: capture ALU output, release the ALU bus.
        S_EXEC: begin
          r_state     <= S_DONE;
          r_res_valid <= 1'b1;
          r_alu_A     <= '0;
          r_alu_B     <= '0;
          r_alu_op    <= '0;
          if (f_is_arith(r_op)) begin
            r_res_S    <= bus.alu_S;
            r_res_flag <= bus.alu_flag;
            r_res_err  <= 1'b0;
          end else if (f_is_cmp(r_op)) begin
            r_res_S    <= f_cmp(r_op, bus.alu_flag[1],
                                bus.alu_flag[2] ^ bus.alu_flag[3]);
            r_res_flag <= bus.alu_flag;
            r_res_err  <= 1'b0;
          end else begin
            r_res_S    <= '0;
            r_res_flag <= '0;
            r_res_err  <= 1'b1;
          end
        end
        // Done: hold result until the consumer takes it.
        S_DONE: begin
          if (bus.res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_op_cnt    <= r_op_cnt + 16'd1;
            if (!r_res_err)
              r_flags_q <= r_res_flag;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.alu_A     = r_alu_A;
  assign bus.alu_B     = r_alu_B;
  assign bus.alu_op    = r_alu_op;
  assign bus.res_valid = r_res_valid;
  assign bus.res_S     = r_res_S;
  assign bus.res_flag  = r_res_flag;
  assign bus.res_err   = r_res_err;
  assign bus.flags_q   = r_flags_q;
  assign bus.op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_ual_issue.sv
// ---------------------------------------------------------------------------
// tb_ual_issue : bench for ual_issue. Provides a combinational ALU model on
// the alu_* bus and predicts results from the operands directly (signed
// compares evaluated with $signed arithmetic).
// ---------------------------------------------------------------------------
module tb_ual_issue;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] m_cnt;
  logic [4:0]  m_flags;

  ual_issue_if bus ();

  ual_issue dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // ALU: returns {E,O,N,Z,C,S}
  function automatic logic [20:0] alu_fn(input logic [4:0] op,
                                         input logic [15:0] a, b);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] s;
    logic c, o, e;
    s = 16'h0; c = 1'b0; o = 1'b0; e = 1'b0;
    case (op)
      5'h01: begin w = {1'b0, a} + {1'b0, b}; s = w[15:0]; c = w[16];
                   o = (a[15] == b[15]) && (s[15] != a[15]); end
      5'h02: begin p = a * b; s = p[15:0]; c = |p[31:16]; end
      5'h03: begin w = {1'b0, a} - {1'b0, b}; s = w[15:0]; c = w[16];
                   o = (a[15] != b[15]) && (s[15] != a[15]); end
      5'h04: begin if (b == 16'h0) begin s = 16'hFFFF; e = 1'b1; end
                   else s = a / b; end
      default: s = 16'h0;
    endcase
    return {e, o, s[15], (s == 16'h0), c, s};
  endfunction

  logic [20:0] alu_out;
  assign alu_out      = alu_fn(bus.alu_op, bus.alu_A, bus.alu_B);
  assign bus.alu_S    = alu_out[15:0];
  assign bus.alu_flag = alu_out[20:16];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference prediction: {err, flags, S} plus expected ALU opcode in EXEC.
  task automatic predict(input logic [4:0] op, input logic [15:0] a, b,
                         output logic [15:0] eS, output logic [4:0] eF,
                         output logic eErr, output logic [4:0] eAop);
    logic [20:0] r;
    int sa, sb;
    sa = $signed(a); sb = $signed(b);
    eErr = 1'b0;
    if (op >= 5'h01 && op <= 5'h04) begin
      r = alu_fn(op, a, b); eS = r[15:0]; eF = r[20:16]; eAop = op;
    end else if (op >= 5'h09 && op <= 5'h0D) begin
      r = alu_fn(5'h03, a, b); eF = r[20:16]; eAop = 5'h03;
      case (op)
        5'h09:   eS = {15'd0, sa == sb};
        5'h0A:   eS = {15'd0, sa <  sb};
        5'h0B:   eS = {15'd0, sa <= sb};
        5'h0C:   eS = {15'd0, sa >  sb};
        default: eS = {15'd0, sa >= sb};
      endcase
    end else begin
      eS = 16'h0; eF = 5'h0; eErr = 1'b1; eAop = 5'h0;
    end
  endtask

  // One full transaction with bp cycles of result backpressure.
  task automatic do_op(input logic [4:0] op, input logic [15:0] a, b,
                       input int bp);
    logic [15:0] eS; logic [4:0] eF, eAop; logic eErr;
    predict(op, a, b, eS, eF, eErr, eAop);
    chk("idle_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op = 5'($urandom); bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
    chk("exec_alu_op", bus.alu_op, eAop);
    chk("exec_alu_A", bus.alu_A, a);
    chk("exec_alu_B", bus.alu_B, b);
    chk("exec_valid", bus.res_valid, 0);
    chk("exec_ready", bus.req_ready, 0);
    tick();
    chk("done_valid", bus.res_valid, 1);
    chk("done_S", bus.res_S, eS);
    chk("done_flag", bus.res_flag, eF);
    chk("done_err", bus.res_err, eErr);
    chk("done_alu_op", bus.alu_op, 0);
    chk("done_ready", bus.req_ready, 0);
    for (int i = 0; i < bp; i++) begin
      bus.req_valid = 1'b1;
      tick();
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_S", bus.res_S, eS);
      chk("bp_flag", bus.res_flag, eF);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_cnt", bus.op_cnt, m_cnt);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    m_cnt = m_cnt + 16'd1;
    if (!eErr) m_flags = eF;
    chk("hs_valid", bus.res_valid, 0);
    chk("hs_ready", bus.req_ready, 1);
    chk("hs_cnt", bus.op_cnt, m_cnt);
    chk("hs_flags_q", bus.flags_q, m_flags);
  endtask

  logic [4:0] op_tab [12] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h09, 5'h0A,
                              5'h0B, 5'h0C, 5'h0D, 5'h1F, 5'h00, 5'h0E};

  initial begin
    m_cnt = 16'h0; m_flags = 5'h0;
    bus.req_valid = 1'b1; bus.req_op = 5'h01;
    bus.req_a = 16'h1111; bus.req_b = 16'h2222; bus.res_ready = 1'b0;

    // Reset with a request present: not accepted.
    repeat (3) tick();
    RST = 1'b0; bus.req_valid = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_S", bus.res_S, 0);
    chk("rst_res_flag", bus.res_flag, 0);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_flags_q", bus.flags_q, 0);
    chk("rst_op_cnt", bus.op_cnt, 0);
    chk("rst_alu_A", bus.alu_A, 0);
    chk("rst_alu_B", bus.alu_B, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    tick();
    chk("rst_no_accept", bus.req_ready, 1);
    chk("rst_no_exec", bus.alu_op, 0);

    // Directed cases.
    do_op(5'h01, 16'h0005, 16'h0003, 0);
    chk("add_S_value", bus.res_S, 16'h0008);
    chk("add_cnt_one", bus.op_cnt, 16'h0001);
    do_op(5'h0A, 16'hFFFE, 16'h0001, 0);
    chk("inf_true", bus.res_S, 16'h0001);
    do_op(5'h0D, 16'hFFFE, 16'h0001, 0);
    chk("supe_false", bus.res_S, 16'h0000);
    do_op(5'h09, 16'h1234, 16'h1234, 0);
    chk("equ_true", bus.res_S, 16'h0001);
    do_op(5'h02, 16'h0100, 16'h0300, 5);
    do_op(5'h1F, 16'h00AA, 16'h0055, 1);
    chk("bad_S", bus.res_S, 0);
    chk("bad_err", bus.res_err, 1);
    do_op(5'h04, 16'h1234, 16'h0000, 0);
    chk("div0_E", bus.res_flag[4], 1);
    chk("div0_err", bus.res_err, 0);
    do_op(5'h01, 16'h7FFF, 16'h0001, 0);

    // Randomised operations.
    for (int n = 0; n < 30; n++) begin
      logic [4:0] op; logic [15:0] a, b;
      op = op_tab[$urandom_range(0, 11)];
      a  = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) b = 16'h0;
      do_op(op, a, b, $urandom_range(0, 2));
    end

    // Reset while in EXEC.
    bus.req_valid = 1'b1; bus.req_op = 5'h01; bus.req_a = 16'h0001; bus.req_b = 16'h0001;
    tick();
    bus.req_valid = 1'b0;
    chk("rexec_in_exec", bus.alu_op, 5'h01);
    RST = 1'b1; tick(); RST = 1'b0;
    m_cnt = 16'h0; m_flags = 5'h0;
    chk("rexec_ready", bus.req_ready, 1);
    chk("rexec_valid", bus.res_valid, 0);
    chk("rexec_cnt", bus.op_cnt, m_cnt);
    bus.res_ready = 1'b1;
    repeat (3) begin tick(); chk("rexec_no_stale", bus.res_valid, 0); end
    bus.res_ready = 1'b0;
    do_op(5'h03, 16'h0010, 16'h0004, 0);

    // Reset while in DONE.
    bus.req_valid = 1'b1; bus.req_op = 5'h02; bus.req_a = 16'h0003; bus.req_b = 16'h0004;
    tick(); bus.req_valid = 1'b0; tick();
    chk("rdone_in_done", bus.res_valid, 1);
    RST = 1'b1; tick(); RST = 1'b0;
    m_cnt = 16'h0; m_flags = 5'h0;
    chk("rdone_ready", bus.req_ready, 1);
    chk("rdone_valid", bus.res_valid, 0);
    chk("rdone_cnt", bus.op_cnt, m_cnt);
    bus.res_ready = 1'b1;
    repeat (3) begin tick(); chk("rdone_no_stale", bus.res_valid, 0); end
    bus.res_ready = 1'b0;
    chk("rdone_cnt_later", bus.op_cnt, m_cnt);

    // Counter wrap: preload near the top, then complete operations.
    force dut.r_op_cnt = 16'hFFFE;
    #1;
    release dut.r_op_cnt;
    m_cnt = 16'hFFFE;
    chk("wrap_preload", bus.op_cnt, 16'hFFFE);
    do_op(5'h01, 16'h0002, 16'h0002, 0);
    do_op(5'h01, 16'h0002, 16'h0003, 0);
    chk("wrap_zero", bus.op_cnt, 16'h0000);

    // Back-to-back with req_valid held: accept every third cycle.
    bus.req_valid = 1'b1; bus.req_op = 5'h01; bus.req_a = 16'h8000; bus.req_b = 16'h8000;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_accept", bus.req_ready, (i % 3) == 0);
      tick();
    end
    bus.req_valid = 1'b0; bus.res_ready = 1'b0;
    m_cnt = m_cnt + 16'd4;
    m_flags = 5'b01011;  // 0x8000+0x8000: C, Z, O set
    chk("b2b_ready_end", bus.req_ready, 1);
    chk("b2b_cnt", bus.op_cnt, m_cnt);
    chk("b2b_flags_q", bus.flags_q, m_flags);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
